alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_cmd_sequencer_if.sv | 46 ++++
 rtl/alu_sticky_flags.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the bit layout of the response flag vector.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 5'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 5'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
    localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
    localparam logic [OP_W-1:0] OP_SLT  = 5'd9;
    localparam logic [OP_W-1:0] OP_SLTU = 5'd10;
    localparam logic [OP_W-1:0] OP_EQ   = 5'd11;
    localparam logic [OP_W-1:0] OP_NEQ  = 5'd12;
    localparam logic [OP_W-1:0] OP_GT   = 5'd13;
    localparam logic [OP_W-1:0] OP_LT   = 5'd14;
    localparam logic [OP_W-1:0] OP_PASS = 5'd15;

    // Bit positions inside rsp_flags = {overflow, carry, negative, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal_opcode(input logic [OP_W-1:0] op);
        return (op[OP_W-1] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command stream, ALU operand/result bus and response stream of the sequencer.
// "slave" is the sequencer's view; "master" is the surrounding system's view.
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_chain;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_negative;
    logic              alu_carry_out;
    logic              alu_overflow;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_illegal;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_zero, alu_negative, alu_carry_out, alu_overflow,
        output rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_zero, alu_negative, alu_carry_out, alu_overflow,
        input  rsp_valid, rsp_result, rsp_flags, rsp_illegal,
        output rsp_ready
    );

endinterface

// File: rtl/alu_sticky_flags.sv
// Sticky status bits: each one sets on its pulse and holds until cleared;
// a set in the same cycle as a clear wins.
module alu_sticky_flags #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] set,
    input  logic         clr,
    output logic [N-1:0] sticky
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            logic sticky_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_reg <= 1'b0;
                end else if (set[gi]) begin
                    sticky_reg <= 1'b1;
                end else if (clr) begin
                    sticky_reg <= 1'b0;
                end
            end

            assign sticky[gi] = sticky_reg;
        end
    endgenerate

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registers commands onto an external combinational ALU, captures its result
// and flags, and returns them on a valid/ready response stream.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    input  logic                clr_sticky,
    output logic                sticky_carry,
    output logic                sticky_overflow,
    output logic [15:0]         op_count
);

    state_e            state_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [OP_W-1:0]   alu_opcode_reg;
    logic              illegal_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic [3:0]        rsp_flags_reg;
    logic              rsp_illegal_reg;
    logic [DATA_W-1:0] last_result_reg;
    logic [15:0]       op_count_reg;

    logic              accept;
    logic              rsp_fire;
    logic              cmd_legal;
    logic [DATA_W-1:0] chain_src;
    logic [3:0]        alu_flags;
    logic [1:0]        sticky_set;
    logic [1:0]        sticky_q;

    assign bus.cmd_ready = (state_reg == IDLE) || ((state_reg == RESP) && bus.rsp_ready);
    assign bus.rsp_valid = (state_reg == RESP);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign cmd_legal     = is_legal_opcode(bus.cmd_opcode);

    // A chained command accepted during the handshake must see the result
    // being handed off, which last_result only picks up at this same edge.
    assign chain_src = (rsp_fire && !rsp_illegal_reg) ? rsp_result_reg : last_result_reg;

    always_comb begin
        alu_flags             = 4'b0000;
        alu_flags[FLAG_ZERO]  = bus.alu_zero;
        alu_flags[FLAG_NEG]   = bus.alu_negative;
        alu_flags[FLAG_CARRY] = bus.alu_carry_out;
        alu_flags[FLAG_OVF]   = bus.alu_overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_opcode_reg  <= '0;
            illegal_reg     <= 1'b0;
            rsp_result_reg  <= '0;
            rsp_flags_reg   <= '0;
            rsp_illegal_reg <= 1'b0;
            last_result_reg <= '0;
            op_count_reg    <= '0;
        end else begin
            if (accept) begin
                illegal_reg <= !cmd_legal;
                if (cmd_legal) begin
                    alu_opcode_reg <= bus.cmd_opcode;
                    alu_a_reg      <= bus.cmd_chain ? chain_src : bus.cmd_a;
                    alu_b_reg      <= bus.cmd_b;
                end else begin
                    alu_opcode_reg <= OP_PASS;
                    alu_a_reg      <= '0;
                    alu_b_reg      <= '0;
                end
            end

            if (rsp_fire) begin
                op_count_reg <= op_count_reg + 16'd1;
                if (!rsp_illegal_reg) begin
                    last_result_reg <= rsp_result_reg;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_reg  <= illegal_reg ? '0 : bus.alu_result;
                    rsp_flags_reg   <= illegal_reg ? 4'b0000 : alu_flags;
                    rsp_illegal_reg <= illegal_reg;
                    state_reg       <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        state_reg <= accept ? EXEC : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sticky_set[0] = rsp_fire && rsp_flags_reg[FLAG_CARRY];
    assign sticky_set[1] = rsp_fire && rsp_flags_reg[FLAG_OVF];

    alu_sticky_flags #(.N(2)) u_sticky (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (sticky_set),
        .clr    (clr_sticky),
        .sticky (sticky_q)
    );

    assign sticky_carry    = sticky_q[0];
    assign sticky_overflow = sticky_q[1];

    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_opcode  = alu_opcode_reg;
    assign bus.rsp_result  = rsp_result_reg;
    assign bus.rsp_flags   = rsp_flags_reg;
    assign bus.rsp_illegal = rsp_illegal_reg;
    assign op_count        = op_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU closes the loop and a
// transaction-level model predicts every response and status output.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_sticky = 1'b0;
    logic        sticky_carry;
    logic        sticky_overflow;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .clr_sticky      (clr_sticky),
        .sticky_carry    (sticky_carry),
        .sticky_overflow (sticky_overflow),
        .op_count        (op_count)
    );

    // Returns {overflow, carry(borrow for SUB), negative, zero, result}
    function automatic logic [35:0] alu_eval(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        v;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            5'd0:  begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1:  begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = a << b[4:0];
            5'd7:  r = a >> b[4:0];
            5'd8:  r = 32'($signed(a) >>> b[4:0]);
            5'd9:  r = {31'd0, $signed(a) < $signed(b)};
            5'd10: r = {31'd0, a < b};
            5'd11: r = {31'd0, a == b};
            5'd12: r = {31'd0, a != b};
            5'd13: r = {31'd0, $signed(a) > $signed(b)};
            5'd14: r = {31'd0, a < b};
            5'd15: r = a;
            default: r = 32'd0;
        endcase
        return {v, c, r[31], (r == 32'd0), r};
    endfunction

    always_comb begin
        {bus.alu_overflow, bus.alu_carry_out, bus.alu_negative, bus.alu_zero, bus.alu_result} =
            alu_eval(bus.alu_opcode, bus.alu_a, bus.alu_b);
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] model_last = 32'd0;
    logic        m_sc = 1'b0;
    logic        m_so = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    bit          pend = 1'b0;
    logic [31:0] p_res, p_a, p_b;
    logic [3:0]  p_flags;
    logic [4:0]  p_op;
    logic        p_ill;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag);
        check_val({tag, "_valid"},   32'(bus.rsp_valid),   32'd1);
        check_val({tag, "_result"},  bus.rsp_result,       p_res);
        check_val({tag, "_flags"},   32'(bus.rsp_flags),   32'(p_flags));
        check_val({tag, "_illegal"}, 32'(bus.rsp_illegal), 32'(p_ill));
        check_val({tag, "_alu_a"},   bus.alu_a,            p_a);
        check_val({tag, "_alu_op"},  32'(bus.alu_opcode),  32'(p_op));
    endtask

    // Model update for a response handshake that happened at the last edge
    task automatic retire(input bit clr);
        if (!p_ill) model_last = p_res;
        if (p_flags[2]) m_sc = 1'b1; else if (clr) m_sc = 1'b0;
        if (p_flags[3]) m_so = 1'b1; else if (clr) m_so = 1'b0;
        m_cnt = m_cnt + 16'd1;
        pend  = 1'b0;
        check_val("sticky_carry",    32'(sticky_carry),    32'(m_sc));
        check_val("sticky_overflow", 32'(sticky_overflow), 32'(m_so));
        check_val("op_count",        32'(op_count),        32'(m_cnt));
        $display("rsp  result=%h flags=%b illegal=%0d count=%0d", p_res, p_flags, p_ill, m_cnt);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit chain, input bit clr);
        logic [31:0] ea;
        logic [35:0] ev;
        bit          was_pend;
        was_pend       = pend;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_chain  = chain;
        bus.rsp_ready  = was_pend;
        clr_sticky     = was_pend && clr;
        #1;
        check_val("cmd_ready_accept", 32'(bus.cmd_ready), 32'd1);
        if (was_pend) check_rsp("handoff");
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        clr_sticky    = 1'b0;
        bus.cmd_a     = $urandom;
        if (was_pend) retire(clr);
        ea = chain ? model_last : a;
        if (op < 5'd16) begin
            ev      = alu_eval(op, ea, b);
            p_op    = op;
            p_a     = ea;
            p_b     = b;
            p_res   = ev[31:0];
            p_flags = ev[35:32];
            p_ill   = 1'b0;
        end else begin
            p_op    = 5'd15;
            p_a     = 32'd0;
            p_b     = 32'd0;
            p_res   = 32'd0;
            p_flags = 4'd0;
            p_ill   = 1'b1;
        end
        check_val("exec_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        check_val("exec_cmd_ready", 32'(bus.cmd_ready),  32'd0);
        check_val("exec_alu_op",    32'(bus.alu_opcode), 32'(p_op));
        check_val("exec_alu_a",     bus.alu_a,           p_a);
        check_val("exec_alu_b",     bus.alu_b,           p_b);
        tick();
        pend = 1'b1;
        check_rsp("resp");
        $display("cmd  op=%0d a=%h b=%h chain=%0d -> exp result=%h flags=%b illegal=%0d",
                 op, ea, b, chain, p_res, p_flags, p_ill);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rsp_ready = 1'b0;
            bus.cmd_valid = 1'($urandom % 2);
            #1;
            check_val("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_rsp("hold");
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input bit clr);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        clr_sticky    = clr;
        #1;
        check_val("drain_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_rsp("drain");
        tick();
        bus.rsp_ready = 1'b0;
        clr_sticky    = 1'b0;
        retire(clr);
        check_val("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 5'd0;
        bus.cmd_a      = 32'd0;
        bus.cmd_b      = 32'd0;
        bus.cmd_chain  = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check_val("rst_cmd_ready",  32'(bus.cmd_ready),   32'd1);
        check_val("rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
        check_val("rst_alu_a",      bus.alu_a,            32'd0);
        check_val("rst_alu_b",      bus.alu_b,            32'd0);
        check_val("rst_alu_op",     32'(bus.alu_opcode),  32'd0);
        check_val("rst_rsp_result", bus.rsp_result,       32'd0);
        check_val("rst_rsp_flags",  32'(bus.rsp_flags),   32'd0);
        check_val("rst_illegal",    32'(bus.rsp_illegal), 32'd0);
        check_val("rst_op_count",   32'(op_count),        32'd0);
        check_val("rst_sticky_c",   32'(sticky_carry),    32'd0);
        check_val("rst_sticky_v",   32'(sticky_overflow), 32'd0);

        // Carry out of an all-ones add
        issue(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_val("add_carry_flags", 32'(bus.rsp_flags), 32'h5);
        drain(1'b0);
        // Signed overflow on subtract, then clear racing a new overflow
        issue(5'd1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        check_val("sub_ovf_flags", 32'(bus.rsp_flags), 32'h8);
        drain(1'b0);
        issue(5'd1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        drain(1'b1);
        check_val("sticky_ovf_set_wins", 32'(sticky_overflow), 32'd1);
        // Chained shift issued in the handshake cycle of the add
        issue(5'd0, 32'd5, 32'd3, 1'b0, 1'b0);
        issue(5'd6, 32'h1234_5678, 32'd2, 1'b1, 1'b0);
        check_val("chain_result", bus.rsp_result, 32'd32);
        drain(1'b0);
        // Illegal opcode leaves last_result alone
        issue(5'd20, 32'h0000_DEAD, 32'h55, 1'b0, 1'b0);
        drain(1'b0);
        issue(5'd0, 32'hFFFF, 32'd0, 1'b1, 1'b0);
        check_val("post_illegal_chain", bus.rsp_result, 32'd32);
        // Backpressure, then same-cycle accept on release
        hold(5);
        issue(5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0);
        drain(1'b0);

        // Asynchronous reset while a command is in EXEC
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 5'd3;
        bus.cmd_a      = 32'h1111;
        bus.cmd_b      = 32'h2222;
        bus.cmd_chain  = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("arst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        check_val("arst_cmd_ready", 32'(bus.cmd_ready),  32'd1);
        check_val("arst_alu_a",     bus.alu_a,           32'd0);
        check_val("arst_alu_op",    32'(bus.alu_opcode), 32'd0);
        check_val("arst_op_count",  32'(op_count),       32'd0);
        check_val("arst_sticky_v",  32'(sticky_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 32'd0;
        m_sc = 1'b0;
        m_so = 1'b0;
        m_cnt = 16'd0;
        pend = 1'b0;
        tick();
        check_val("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        issue(5'd0, 32'hAAAA, 32'd7, 1'b1, 1'b0);
        check_val("rel_last_zero", bus.rsp_result, 32'd7);
        drain(1'b0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom % 8 == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
            a  = ($urandom % 4 == 0) ? 32'h8000_0000 - 32'($urandom % 3) : $urandom;
            b  = ($urandom % 3 == 0) ? 32'($urandom % 40) : $urandom;
            if ($urandom % 6 == 0) b = a;
            if (pend) begin
                if ($urandom % 3 == 0) hold(int'($urandom % 3) + 1);
                if ($urandom % 2 == 0) drain(1'($urandom % 3 == 0));
            end
            issue(op, a, b, 1'($urandom % 3 == 0), 1'($urandom % 3 == 0));
        end
        if (pend) drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
